distribute_in_multimode: RTL and testbench

//  Next-generation activation/weight distributor between N READ channels and M compute lanes.

---
 rtl/distribute_in_multimode_pkg.sv | 21 ++
 rtl/distribute_in_multimode_if.sv | 32 +++
 rtl/distribute_in_multimode_lane_out_reg.sv | 31 +++
 rtl/distribute_in_multimode.sv | 154 +++++++++++++++
 tb/tb_distribute_in_multimode.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/distribute_in_multimode_pkg.sv
// rtl/distribute_in_multimode_pkg.sv - shared mode/state encodings and counter width helper
package distribute_in_multimode_pkg;

  typedef enum logic [1:0] {
    MODE_BCAST = 2'd0,
    MODE_1TO1  = 2'd1,
    MODE_RR    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Counters must hold num_iters*num_reads_per_iter at its maximum.
  function automatic int cnt_width(input int log_iters, input int log_reads);
    return log_iters + log_reads;
  endfunction

endpackage

// File: rtl/distribute_in_multimode_if.sv
// rtl/distribute_in_multimode_if.sv - activation/weight stream bundle between readers, distributor and lanes
interface distribute_in_multimode_if #(
  parameter int NUM_DATA_INPUTS  = 4,
  parameter int NUM_DATA_OUTPUTS = 4,
  parameter int GROUP_SIZE       = 2,
  parameter int DATA_WIDTH       = 8
);
  localparam int AW = GROUP_SIZE * DATA_WIDTH;

  logic [NUM_DATA_INPUTS*AW-1:0]          act_data_in;
  logic [NUM_DATA_INPUTS-1:0]             act_valid_in;
  logic [NUM_DATA_INPUTS-1:0]             act_avail_out;
  logic [NUM_DATA_OUTPUTS*DATA_WIDTH-1:0] weights_data_in;
  logic                                   weights_valid_in;
  logic                                   weights_avail_out;
  logic [NUM_DATA_OUTPUTS*AW-1:0]         data_out;
  logic [NUM_DATA_OUTPUTS-1:0]            valid_out;
  logic [NUM_DATA_OUTPUTS-1:0]            avail_in;
  logic [NUM_DATA_OUTPUTS*DATA_WIDTH-1:0] weights_data_out;
  logic [NUM_DATA_OUTPUTS-1:0]            weights_valid_out;
  logic [NUM_DATA_OUTPUTS-1:0]            weights_avail_in;

  modport master (
    output act_data_in, act_valid_in, weights_data_in, weights_valid_in, avail_in, weights_avail_in,
    input  act_avail_out, weights_avail_out, data_out, valid_out, weights_data_out, weights_valid_out
  );

  modport slave (
    input  act_data_in, act_valid_in, weights_data_in, weights_valid_in, avail_in, weights_avail_in,
    output act_avail_out, weights_avail_out, data_out, valid_out, weights_data_out, weights_valid_out
  );
endinterface

// File: rtl/distribute_in_multimode_lane_out_reg.sv
// rtl/distribute_in_multimode_lane_out_reg.sv - one-entry valid/avail output register for a single lane
module distribute_in_multimode_lane_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             avail,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             free
);
  // Free when empty or being drained this cycle, so back-to-back words see no bubble.
  assign free = !valid || avail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (avail) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/distribute_in_multimode.sv
// rtl/distribute_in_multimode.sv - activation/weight distributor: mode routing, run counters and FSM
module distribute_in_multimode
  import distribute_in_multimode_pkg::*;
#(
  parameter int NUM_DATA_INPUTS        = 4,
  parameter int NUM_DATA_OUTPUTS       = 4,
  parameter int GROUP_SIZE             = 2,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 4,
  parameter int LOG_MAX_READS_PER_ITER = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [1:0]                        conf_mode,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  distribute_in_multimode_if.slave          bus,
  output logic                              done
);
  localparam int NI   = NUM_DATA_INPUTS;
  localparam int NO   = NUM_DATA_OUTPUTS;
  localparam int AW   = GROUP_SIZE * DATA_WIDTH;
  localparam int CW   = cnt_width(LOG_MAX_ITERS, LOG_MAX_READS_PER_ITER);
  localparam int NMIN = (NI < NO) ? NI : NO;
  localparam int PW   = (NO > 1) ? $clog2(NO) : 1;

  state_e          state, state_nxt;
  mode_e           mode_q;
  logic [CW-1:0]   total_q, cfg_total, wt_cnt;
  logic [CW-1:0]   act_cnt [NI];
  logic [PW-1:0]   rr_ptr;
  logic [NI-1:0]   act_active, act_left, act_avail, act_xfer;
  logic [NO-1:0]   slot_free, wslot_free, lane_load;
  logic [AW-1:0]   lane_din [NO];
  logic            run_ok, wt_avail, wt_xfer, all_counted, all_empty;

  assign cfg_total = {{(CW-LOG_MAX_ITERS){1'b0}}, num_iters} *
                     {{(CW-LOG_MAX_READS_PER_ITER){1'b0}}, num_reads_per_iter};

  // A same-cycle configure suppresses every handshake so no word is half-accepted.
  assign run_ok    = (state == RUN) && !configure;
  assign all_empty = ~|bus.valid_out && ~|bus.weights_valid_out;

  always_comb begin
    act_avail = '0;
    for (int i = 0; i < NI; i++) begin
      act_active[i] = (mode_q == MODE_1TO1) ? (i < NMIN) : (i == 0);
      act_left[i]   = (act_cnt[i] != total_q);
    end
    if (run_ok) begin
      case (mode_q)
        MODE_1TO1: for (int i = 0; i < NMIN; i++) act_avail[i] = act_left[i] && slot_free[i];
        MODE_RR:   act_avail[0] = act_left[0] && slot_free[rr_ptr];
        default:   act_avail[0] = act_left[0] && (&slot_free);
      endcase
    end
  end

  assign act_xfer              = act_avail & bus.act_valid_in;
  assign wt_avail              = run_ok && (wt_cnt != total_q) && (&wslot_free);
  assign wt_xfer               = wt_avail && bus.weights_valid_in;
  assign bus.act_avail_out     = act_avail;
  assign bus.weights_avail_out = wt_avail;

  always_comb begin
    for (int l = 0; l < NO; l++) begin
      lane_load[l] = 1'b0;
      lane_din[l]  = bus.act_data_in[0 +: AW];
      case (mode_q)
        MODE_1TO1: if (l < NMIN) begin
          lane_load[l] = act_xfer[l];
          lane_din[l]  = bus.act_data_in[l*AW +: AW];
        end
        MODE_RR:   lane_load[l] = act_xfer[0] && (rr_ptr == PW'(l));
        default:   lane_load[l] = act_xfer[0];
      endcase
    end
  end

  for (genvar l = 0; l < NO; l++) begin : g_lane
    distribute_in_multimode_lane_out_reg #(.WIDTH(AW)) u_act (
      .clk   (clk),
      .rst   (rst),
      .clear (configure),
      .load  (lane_load[l]),
      .din   (lane_din[l]),
      .avail (bus.avail_in[l]),
      .dout  (bus.data_out[l*AW +: AW]),
      .valid (bus.valid_out[l]),
      .free  (slot_free[l])
    );
    distribute_in_multimode_lane_out_reg #(.WIDTH(DATA_WIDTH)) u_wt (
      .clk   (clk),
      .rst   (rst),
      .clear (configure),
      .load  (wt_xfer),
      .din   (bus.weights_data_in[l*DATA_WIDTH +: DATA_WIDTH]),
      .avail (bus.weights_avail_in[l]),
      .dout  (bus.weights_data_out[l*DATA_WIDTH +: DATA_WIDTH]),
      .valid (bus.weights_valid_out[l]),
      .free  (wslot_free[l])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_BCAST;
      total_q <= '0;
      wt_cnt  <= '0;
      rr_ptr  <= '0;
      for (int i = 0; i < NI; i++) act_cnt[i] <= '0;
    end else if (configure) begin
      mode_q  <= (conf_mode == 2'd3) ? MODE_BCAST : mode_e'(conf_mode);
      total_q <= cfg_total;
      wt_cnt  <= '0;
      rr_ptr  <= '0;
      for (int i = 0; i < NI; i++) act_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NI; i++) if (act_xfer[i]) act_cnt[i] <= act_cnt[i] + CW'(1);
      if (wt_xfer) wt_cnt <= wt_cnt + CW'(1);
      if (mode_q == MODE_RR && act_xfer[0])
        rr_ptr <= (rr_ptr == PW'(NO - 1)) ? '0 : rr_ptr + PW'(1);
    end
  end

  always_comb begin
    all_counted = (wt_cnt == total_q);
    for (int i = 0; i < NI; i++) if (act_active[i] && act_left[i]) all_counted = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      RUN:     if (all_counted) state_nxt = DRAIN;
      DRAIN:   if (all_empty) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = state;
    endcase
    // An empty run skips RUN; a configure during a run abandons it without a done.
    if (configure) begin
      state_nxt = (cfg_total == '0) ? DRAIN : RUN;
      done      = 1'b0;
    end
  end
endmodule

// File: tb/tb_distribute_in_multimode.sv
// tb/tb_distribute_in_multimode.sv - randomized scoreboard bench for distribute_in_multimode
module tb_distribute_in_multimode;
  localparam int NI = 4, NO = 4, GS = 2, DW = 8, AW = GS * DW;

  logic       clk = 1'b0, rst = 1'b0, configure = 1'b0;
  logic [1:0] conf_mode = 2'd0;
  logic [3:0] num_iters = 4'd0;
  logic [7:0] num_reads = 8'd0;
  logic       done;

  always #5 clk = ~clk;

  distribute_in_multimode_if #(.NUM_DATA_INPUTS(NI), .NUM_DATA_OUTPUTS(NO),
                               .GROUP_SIZE(GS), .DATA_WIDTH(DW)) bus ();

  distribute_in_multimode #(
    .NUM_DATA_INPUTS(NI), .NUM_DATA_OUTPUTS(NO), .GROUP_SIZE(GS), .DATA_WIDTH(DW),
    .LOG_MAX_ITERS(4), .LOG_MAX_READS_PER_ITER(8)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .conf_mode(conf_mode),
    .num_iters(num_iters), .num_reads_per_iter(num_reads), .bus(bus), .done(done)
  );

  int total = 0, bad = 0;

  // Reference model: expected per-lane word queues plus per-run acceptance counts.
  int          m_mode = 0, m_total = 0, wacc = 0, done_cnt = 0, seq = 0;
  int          acc [NI];
  int          deliv [NO];
  logic [15:0] aq [NO][$];
  logic [7:0]  wq [NO][$];

  bit       full_avail = 0, full_wavail = 0, seq_mode = 0, wfixed = 0;
  logic [3:0] stall_mask = 0, wstall_mask = 0;
  int       stall_left = 0, wstall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit active(input int i);
    return (m_mode == 1) ? 1'b1 : (i == 0);
  endfunction

  task automatic model_clear(input int mode, input int tot);
    m_mode = mode; m_total = tot; wacc = 0; seq = 0;
    for (int i = 0; i < NI; i++) acc[i] = 0;
    for (int l = 0; l < NO; l++) begin deliv[l] = 0; aq[l].delete(); wq[l].delete(); end
  endtask

  task automatic drive();
    bus.act_valid_in = 4'($urandom);
    for (int i = 0; i < NI; i++) bus.act_data_in[i*AW +: AW] = 16'($urandom);
    if (seq_mode) bus.act_data_in[0 +: AW] = 16'(seq);
    bus.avail_in = full_avail ? 4'hf : 4'($urandom | $urandom);
    if (stall_left > 0) begin bus.avail_in &= ~stall_mask; stall_left--; end
    bus.weights_valid_in = 1'($urandom);
    bus.weights_data_in  = wfixed ? 32'h04030201 : $urandom;
    bus.weights_avail_in = full_wavail ? 4'hf : 4'($urandom | $urandom);
    if (wstall_left > 0) begin bus.weights_avail_in &= ~wstall_mask; wstall_left--; end
  endtask

  task automatic cycle();
    int r;
    @(negedge clk);
    for (int l = 0; l < NO; l++) begin
      if (bus.valid_out[l] && bus.avail_in[l]) begin
        if (aq[l].size() == 0) check("act_unexpected", bus.valid_out[l], 1'b0);
        else begin check("act_data", bus.data_out[l*AW +: AW], aq[l].pop_front()); deliv[l]++; end
      end
      if (bus.weights_valid_out[l] && bus.weights_avail_in[l]) begin
        if (wq[l].size() == 0) check("w_unexpected", bus.weights_valid_out[l], 1'b0);
        else check("w_data", bus.weights_data_out[l*DW +: DW], wq[l].pop_front());
      end
    end
    for (int i = 0; i < NI; i++)
      if (!active(i) || acc[i] >= m_total) check("act_avail_off", bus.act_avail_out[i], 1'b0);
    if (m_mode == 0 && |(bus.valid_out & ~bus.avail_in)) check("bcast_stall", bus.act_avail_out[0], 1'b0);
    if (m_mode == 1)
      for (int i = 0; i < NI; i++)
        if (bus.valid_out[i] && !bus.avail_in[i]) check("lane_stall", bus.act_avail_out[i], 1'b0);
    if (m_mode == 2) begin
      r = acc[0] % NO;
      if (bus.valid_out[r] && !bus.avail_in[r]) check("rr_stall", bus.act_avail_out[0], 1'b0);
    end
    if (wacc >= m_total) check("w_avail_off", bus.weights_avail_out, 1'b0);
    if (|(bus.weights_valid_out & ~bus.weights_avail_in)) check("w_stall", bus.weights_avail_out, 1'b0);
    if (!configure) begin
      for (int i = 0; i < NI; i++) begin
        if (bus.act_valid_in[i] && bus.act_avail_out[i] && active(i)) begin
          if (m_mode == 0) for (int l = 0; l < NO; l++) aq[l].push_back(bus.act_data_in[i*AW +: AW]);
          else if (m_mode == 1) aq[i].push_back(bus.act_data_in[i*AW +: AW]);
          else aq[acc[0] % NO].push_back(bus.act_data_in[i*AW +: AW]);
          acc[i]++;
          if (i == 0 && seq_mode) seq++;
        end
      end
      if (bus.weights_valid_in && bus.weights_avail_out) begin
        for (int l = 0; l < NO; l++) wq[l].push_back(bus.weights_data_in[l*DW +: DW]);
        wacc++;
      end
    end
    if (done) begin
      done_cnt++;
      check("done_valids", {bus.valid_out, bus.weights_valid_out}, '0);
      for (int l = 0; l < NO; l++) check("done_q_empty", aq[l].size() + wq[l].size(), 0);
      for (int i = 0; i < NI; i++) check("done_acc", acc[i], active(i) ? m_total : 0);
      check("done_wacc", wacc, m_total);
    end
    if (configure) model_clear((conf_mode == 2'd3) ? 0 : int'(conf_mode), num_iters * num_reads);
    @(posedge clk);
    #1;
  endtask

  task automatic do_configure(input int mode, input int iters, input int reads);
    drive();
    conf_mode = 2'(mode); num_iters = 4'(iters); num_reads = 8'(reads);
    configure = 1'b1;
    cycle();
    configure = 1'b0;
  endtask

  task automatic run_to_done(input int max_cycles);
    int  d0;
    bit  seen;
    d0 = done_cnt; seen = 0;
    for (int c = 0; c < max_cycles; c++) begin
      drive(); cycle();
      if (done_cnt > d0) begin seen = 1; break; end
    end
    check("run_timeout", seen, 1'b1);
    repeat (3) begin drive(); cycle(); end
    check("done_once", done_cnt - d0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  bus.valid_out, '0);
    check({tag, "_wvalid"}, bus.weights_valid_out, '0);
    check({tag, "_avail"},  bus.act_avail_out, '0);
    check({tag, "_wavail"}, bus.weights_avail_out, 1'b0);
    check({tag, "_done"},   done, 1'b0);
    check({tag, "_data"},   bus.data_out, '0);
    check({tag, "_wdata"},  bus.weights_data_out, '0);
  endtask

  initial begin
    int d0, sum;
    model_clear(0, 0);
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin drive(); cycle(); end

    // one-to-one, full downstream throughput
    full_avail = 1; full_wavail = 1;
    do_configure(1, 2, 4);
    run_to_done(400);
    for (int l = 0; l < NO; l++) check("t1_lane_count", deliv[l], 8);

    // broadcast with lane 2 stalled
    full_avail = 0; full_wavail = 0;
    stall_mask = 4'b0100; stall_left = 20;
    do_configure(0, 1, 6);
    run_to_done(800);
    for (int l = 0; l < NO; l++) check("t2_lane_count", deliv[l], 6);

    // round-robin with sequential words 0..9
    seq_mode = 1;
    do_configure(2, 2, 5);
    run_to_done(800);
    seq_mode = 0;
    for (int l = 0; l < NO; l++) check("t3_rr_count", deliv[l], (l < 2) ? 3 : 2);

    // fixed weight word with weight lane 0 stalled
    wfixed = 1; full_avail = 1; wstall_mask = 4'b0001; wstall_left = 12;
    do_configure(1, 1, 4);
    run_to_done(800);
    wfixed = 0; full_avail = 0;

    // abort after 3 words, restart in broadcast
    do_configure(1, 4, 8);
    sum = 0;
    for (int c = 0; c < 200 && sum < 3; c++) begin
      drive(); cycle();
      sum = acc[0] + acc[1] + acc[2] + acc[3];
    end
    check("abort_reach3", sum >= 3, 1'b1);
    d0 = done_cnt;
    do_configure(0, 1, 4);
    check("abort_valid_clr", bus.valid_out, '0);
    check("abort_wvalid_clr", bus.weights_valid_out, '0);
    check("abort_no_done", done_cnt - d0, 0);
    run_to_done(800);
    for (int l = 0; l < NO; l++) check("t5_lane_count", deliv[l], 4);

    // empty run
    d0 = done_cnt;
    do_configure(1, 0, 5);
    check("zero_avail", bus.act_avail_out, '0);
    check("zero_wavail", bus.weights_avail_out, 1'b0);
    drive(); cycle();
    check("zero_done_next", done_cnt - d0, 1);
    repeat (3) begin drive(); cycle(); end
    check("zero_done_once", done_cnt - d0, 1);

    // asynchronous reset in the middle of a run
    full_avail = 0;
    do_configure(1, 2, 8);
    repeat (6) begin drive(); cycle(); end
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_clear(0, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin drive(); cycle(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
